wb_queue: RTL
=============

// Module: wb_queue
// PURPOSE
//  Writeback queue that drives the single register-file write port (wen/waddr/wdata).
//  Accepts results from EXU (single-cycle ALU) and LSU (multi-cycle loads) over valid/ready.
//  Buffers results in a small in-order FIFO and retires one write per cycle.
//  Exports a pending-register mask so decode can stall reads of not-yet-written regs.
// PARAMETERS
//  DEPTH   4   FIFO entries; power of two, >= 2
//  XLEN    32  data width, matches RV32 register width
//  AW      5   register address width (32 regs)
// PORTS
//  clk        in   1     clock, all state on posedge
//  rst        in   1     asynchronous reset, active-high
//  exu_valid  in   1     EXU result valid
//  exu_ready  out  1     EXU result accepted this cycle
//  exu_rd     in   AW    EXU destination register
//  exu_data   in   XLEN  EXU result
//  lsu_valid  in   1     LSU load result valid
//  lsu_ready  out  1     LSU result accepted this cycle
//  lsu_rd     in   AW    LSU destination register
//  lsu_data   in   XLEN  LSU load data
//  rf_wen     out  1     regfile write enable
//  rf_waddr   out  AW    regfile write address
//  rf_wdata   out  XLEN  regfile write data
//  pend_mask  out  32    bit i = reg i has a queued, unretired write
//  full       out  1     FIFO holds DEPTH entries
// BEHAVIOUR
//  - Clock is clk; reset is asynchronous and active-high (rst). Reset clears wr_ptr,
//    rd_ptr, count; entry contents need no reset.
//  - Reset values: rf_wen=0, rf_waddr=0, rf_wdata=0, pend_mask=0, full=0, exu_ready=1, lsu_ready=1.
//  - Storage: circular FIFO of {rd, data}; wr_ptr/rd_ptr wrap DEPTH-1 -> 0; count 0..DEPTH.
//  - Drain: whenever count>0, head drives rf_waddr/rf_wdata with rf_wen=1 (combinational
//    from head registers); pop occurs on that same posedge. When empty: rf_wen=0, addr/data=0.
//  - Latency: result accepted at edge N is written to regfile at edge N+1 if queue was empty.
//  - Arbitration: at most one enqueue per cycle; LSU has fixed priority over EXU.
//    lsu_ready = space; exu_ready = space & ~lsu_valid; space = (count<DEPTH) | (count>0).
//    (pop and push in same cycle allowed when full; count unchanged.)
//  - Handshake: transfer when valid & ready. Sources hold rd/data stable until accepted;
//    ready never depends on the same source's data.
//  - rd==0: accepted (ready as normal) but not enqueued; no write, no pend bit.
//  - pend_mask: OR over occupied entries of onehot(rd); bit 0 always 0. Combinational
//    from FIFO state (updates the cycle after enqueue, clears the cycle after retire).
//  - Ordering: writes retire in acceptance order; two queued writes to same rd both
//    retire, last accepted wins in the regfile.
//  - full = (count==DEPTH). Empty + push: entry appears at head next cycle (no bypass).
//  - Reset mid-operation: all queued entries discarded immediately; rf_wen drops
//    asynchronously; no partial write is issued.
// TESTING
//  1. Reset with queue half full -> rf_wen=0, pend_mask=0, full=0 immediately, both readys=1.
//  2. EXU rd=5 data=0x1234 one cycle -> next cycle rf_wen=1 waddr=5 wdata=0x1234, pend_mask=0x20.
//  3. EXU rd=3 and LSU rd=7 valid same cycle -> lsu accepted, exu_ready=0; writes retire 7 then 3.
//  4. Stall drain by pushing DEPTH writes back-to-back then keep pushing -> full never stalls
//     since pop each cycle; verify all 8 writes retire in order, no drop, no duplicate.
//  5. EXU rd=0 data=0xdead -> exu_ready=1, rf_wen stays 0, pend_mask stays 0.
//  6. Two writes to rd=9 (0xA then 0xB) -> retire in order, final regfile x9=0xB, bit9 clears after second.

Source files
------------

// File: rtl/wb_queue.sv
// wb_queue: in-order writeback FIFO that arbitrates LSU/EXU results onto the single
// register-file write port and exports a mask of registers with writes still queued.
module wb_queue #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32,
   parameter int AW    = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            exu_valid,
   output logic            exu_ready,
   input  logic [AW-1:0]   exu_rd,
   input  logic [XLEN-1:0] exu_data,
   input  logic            lsu_valid,
   output logic            lsu_ready,
   input  logic [AW-1:0]   lsu_rd,
   input  logic [XLEN-1:0] lsu_data,
   output logic            rf_wen,
   output logic [AW-1:0]   rf_waddr,
   output logic [XLEN-1:0] rf_wdata,
   output logic [31:0]     pend_mask,
   output logic            full
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [AW-1:0]   r_rd   [DEPTH];
   logic [XLEN-1:0] r_data [DEPTH];
   logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
   logic [PW:0]     r_count;

   logic            w_pop, w_space, w_lsu_go, w_exu_go, w_push;
   logic [AW-1:0]   w_push_rd;
   logic [XLEN-1:0] w_push_data;
   logic [31:0]     w_pend;

   // The head retires every cycle it exists, so a push is always accepted when non-empty.
   assign w_pop       = r_count != '0;
   assign w_space     = (r_count < FULL_CNT) | w_pop;
   assign lsu_ready   = w_space;
   assign exu_ready   = w_space & ~lsu_valid;
   assign w_lsu_go    = lsu_valid & lsu_ready;
   assign w_exu_go    = exu_valid & exu_ready;
   assign w_push_rd   = w_lsu_go ? lsu_rd : exu_rd;
   assign w_push_data = w_lsu_go ? lsu_data : exu_data;
   assign w_push      = (w_lsu_go | w_exu_go) & (w_push_rd != '0);

   assign rf_wen    = w_pop;
   assign rf_waddr  = w_pop ? r_rd[r_rd_ptr] : '0;
   assign rf_wdata  = w_pop ? r_data[r_rd_ptr] : '0;
   assign full      = r_count == FULL_CNT;
   assign pend_mask = w_pend;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
         r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_rd[r_wr_ptr]   <= w_push_rd;
         r_data[r_wr_ptr] <= w_push_data;
      end
   end

   always_comb begin
      w_pend = '0;
      for (int i = 0; i < DEPTH; i++)
         if ((PW+1)'(i) < r_count) w_pend[r_rd[r_rd_ptr + PW'(i)]] = 1'b1;
      w_pend[0] = 1'b0;
   end
endmodule
